// File: rtl/hart_mem_arbiter_pkg.sv
// Shared types and defaults for the hart memory-port arbiter.
// Holds the FSM encoding, default sizing and the saturating op counter helper.
package hart_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      HARB_IDLE    = 2'd0,
      HARB_GRANTED = 2'd1,
      HARB_RELEASE = 2'd2
   } harb_state_e;

   localparam int DEF_NHARTS  = 2;
   localparam int DEF_MAX_OPS = 4;

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/hart_mem_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request strictly after ptr, wrapping mod N.
// Purely combinational; the hart at ptr itself is examined last.
module hart_mem_arbiter_rr_pick #(
   parameter int N   = 2,
   parameter int IDW = 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] idx
);

   logic [IDW:0] j;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      found = 1'b0;
      idx   = '0;
      j     = '0;
      for (int k = 1; k <= N; k++) begin
         j = {1'b0, ptr} + (IDW+1)'(k);
         if (j >= (IDW+1)'(N)) j = j - (IDW+1)'(N);
         if (!found && req[j[IDW-1:0]]) begin
            found = 1'b1;
            idx   = j[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Round-robin owner of the shared DRAM/MMU port; one registered one-hot grant per hart.
// Grants only move while DRAM is idle, and an open LR/SC lock is never preempted.
module hart_mem_arbiter
   import hart_mem_arbiter_pkg::*;
#(
   parameter int NHARTS  = DEF_NHARTS,
   parameter int MAX_OPS = DEF_MAX_OPS,
   parameter int IDW     = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NHARTS-1:0] i_req,
   input  logic [NHARTS-1:0] i_lock,
   input  logic              i_dram_busy,
   output logic [NHARTS-1:0] o_grant,
   output logic              o_grant_valid,
   output logic [IDW-1:0]    o_grant_id,
   output logic [2:0]        o_ops_cnt
);

   harb_state_e       state_q, state_d;
   logic [NHARTS-1:0] grant_q, grant_d;
   logic              grant_valid_q, grant_valid_d;
   logic [IDW-1:0]    grant_id_q, grant_id_d;
   logic [2:0]        ops_cnt_q, ops_cnt_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic              busy_q, busy_d;

   logic              pick_found;
   logic [IDW-1:0]    pick_idx;
   logic              op_done;
   logic              own_req, own_lock, other_req;

   hart_mem_arbiter_rr_pick #(.N(NHARTS), .IDW(IDW)) u_rr_pick (
      .req   (i_req),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      ops_cnt_d     = ops_cnt_q;
      rr_ptr_d      = rr_ptr_q;
      busy_d        = i_dram_busy;

      op_done   = busy_q & ~i_dram_busy;
      own_req   = i_req[grant_id_q];
      own_lock  = i_lock[grant_id_q];
      other_req = |(i_req & ~grant_q);

      unique case (state_q)
         // RELEASE is the dead cycle; it arbitrates at its exit so the grant is low exactly once.
         HARB_IDLE, HARB_RELEASE: begin
            state_d = HARB_IDLE;
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               grant_valid_d     = 1'b1;
               grant_id_d        = pick_idx;
               ops_cnt_d         = 3'd0;
               state_d           = HARB_GRANTED;
            end
         end
         HARB_GRANTED: begin
            if (op_done) begin
               ops_cnt_d = sat_inc3(ops_cnt_q);
            end else if (!i_dram_busy && !own_lock &&
                         (!own_req || (int'(ops_cnt_q) >= MAX_OPS && other_req))) begin
               grant_d       = '0;
               grant_valid_d = 1'b0;
               rr_ptr_d      = grant_id_q;
               state_d       = HARB_RELEASE;
            end
         end
         default: begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            state_d       = HARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= HARB_IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         ops_cnt_q     <= 3'd0;
         rr_ptr_q      <= IDW'(NHARTS - 1);
         busy_q        <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         ops_cnt_q     <= ops_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         busy_q        <= busy_d;
      end
   end

   assign o_grant       = grant_q;
   assign o_grant_valid = grant_valid_q;
   assign o_grant_id    = grant_id_q;
   assign o_ops_cnt     = ops_cnt_q;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed bench for hart_mem_arbiter: a 2-hart instance for handoff, preemption, lock,
// busy-hold and async reset, plus a 4-hart instance for rotation order.
module tb_hart_mem_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       busy = 1'b0;

   logic [1:0] req2 = 2'b00, lock2 = 2'b00;
   logic [1:0] g2;
   logic       v2;
   logic [0:0] id2;
   logic [2:0] cnt2;

   logic [3:0] req4 = 4'b0000, lock4 = 4'b0000;
   logic [3:0] g4;
   logic       v4;
   logic [1:0] id4;
   logic [2:0] cnt4;

   int n_checks = 0;
   int n_errors = 0;

   hart_mem_arbiter #(.NHARTS(2), .MAX_OPS(4)) u_dut2 (
      .CLK(CLK), .RST(RST), .i_req(req2), .i_lock(lock2), .i_dram_busy(busy),
      .o_grant(g2), .o_grant_valid(v2), .o_grant_id(id2), .o_ops_cnt(cnt2)
   );

   hart_mem_arbiter #(.NHARTS(4), .MAX_OPS(1)) u_dut4 (
      .CLK(CLK), .RST(RST), .i_req(req4), .i_lock(lock4), .i_dram_busy(busy),
      .o_grant(g4), .o_grant_valid(v4), .o_grant_id(id4), .o_ops_cnt(cnt4)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // one DRAM op: busy high for a cycle, then the falling edge is seen at the next edge
   task automatic busy_pulse();
      busy = 1'b1;
      tick();
      busy = 1'b0;
      tick();
   endtask

   // structural invariants sampled away from the active edge
   always @(negedge CLK) begin
      check("onehot2", 32'($onehot0(g2)), 32'd1);
      check("valid2", 32'(v2), 32'(|g2));
      check("onehot4", 32'($onehot0(g4)), 32'd1);
      check("valid4", 32'(v4), 32'(|g4));
   end

   initial begin
      #2;
      check("rst_grant", 32'(g2), 32'd0);
      check("rst_valid", 32'(v2), 32'd0);
      check("rst_id", 32'(id2), 32'd0);
      check("rst_cnt", 32'(cnt2), 32'd0);
      tick();
      RST = 1'b0;

      // 1: both request, hart0 first; hart0 drops -> one dead cycle -> hart1
      req2 = 2'b11;
      tick();
      check("t1_grant0", 32'(g2), 32'h1);
      check("t1_id0", 32'(id2), 32'd0);
      check("t1_cnt0", 32'(cnt2), 32'd0);
      req2 = 2'b10;
      tick();
      check("t1_dead", 32'(g2), 32'h0);
      tick();
      check("t1_grant1", 32'(g2), 32'h2);
      check("t1_id1", 32'(id2), 32'd1);
      req2 = 2'b00;
      tick();
      check("t1_rel", 32'(g2), 32'h0);
      tick();

      // 2: hart0 holds, hart1 waits; preempted after MAX_OPS completions
      req2 = 2'b11;
      tick();
      check("t2_grant0", 32'(g2), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         busy_pulse();
         check("t2_cnt", 32'(cnt2), 32'(i));
         check("t2_hold", 32'(g2), 32'h1);
      end
      tick();
      check("t2_dead", 32'(g2), 32'h0);
      tick();
      check("t2_grant1", 32'(g2), 32'h2);
      check("t2_cnt_clr", 32'(cnt2), 32'd0);
      req2 = 2'b00;
      tick();
      tick();

      // 3: lock on hart0 blocks preemption until it drops
      req2  = 2'b11;
      lock2 = 2'b01;
      tick();
      check("t3_grant0", 32'(g2), 32'h1);
      for (int i = 1; i <= 6; i++) busy_pulse();
      tick();
      check("t3_cnt", 32'(cnt2), 32'd6);
      check("t3_hold", 32'(g2), 32'h1);
      lock2 = 2'b00;
      tick();
      check("t3_dead", 32'(g2), 32'h0);
      tick();
      check("t3_grant1", 32'(g2), 32'h2);
      req2 = 2'b00;
      tick();
      tick();

      // 4: request dropped while DRAM busy -> held until busy falls
      req2 = 2'b01;
      tick();
      check("t4_grant0", 32'(g2), 32'h1);
      busy = 1'b1;
      tick();
      req2 = 2'b00;
      tick();
      check("t4_busy_a", 32'(g2), 32'h1);
      tick();
      check("t4_busy_b", 32'(g2), 32'h1);
      busy = 1'b0;
      tick();
      check("t4_fall", 32'(g2), 32'h1);
      check("t4_cnt", 32'(cnt2), 32'd1);
      tick();
      check("t4_rel", 32'(g2), 32'h0);
      tick();

      // 5: async reset mid-op; hart1 granted first (ptr=0), reset restores hart0 priority
      req2 = 2'b10;
      tick();
      check("t5_grant1", 32'(g2), 32'h2);
      busy = 1'b1;
      tick();
      #2;
      RST = 1'b1;
      #1;
      check("t5_async_grant", 32'(g2), 32'h0);
      check("t5_async_id", 32'(id2), 32'd0);
      RST  = 1'b0;
      busy = 1'b0;
      req2 = 2'b11;
      tick();
      check("t5_grant0", 32'(g2), 32'h1);
      check("t5_id0", 32'(id2), 32'd0);
      req2 = 2'b00;
      tick();
      tick();

      // 6: four harts, all requesting, one op per tenure -> 0,1,2,3,0
      req4 = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t6_grant", 32'(g4), 32'(4'b0001 << (i % 4)));
         check("t6_id", 32'(id4), 32'(i % 4));
         if (i < 4) begin
            busy_pulse();
            check("t6_cnt", 32'(cnt4), 32'd1);
            tick();
            check("t6_dead", 32'(g4), 32'h0);
            tick();
         end
      end
      req4 = 4'b0000;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
